msj_angle_poll_scheduler: RTL and testbench



---
 rtl/msj_angle_poll_scheduler.sv | 341 ++++++++++++++++++++++++++++++++++
 tb/tb_msj_angle_poll_scheduler.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msj_angle_poll_scheduler.sv
// -----------------------------------------------------------------------------
// msj_angle_poll_scheduler
//
// Purpose:
//   Periodically polls NUMBER_OF_SENSORS A1339 angle sensors that share one
//   SPI master and one MISO line. An internal rate timer issues one tick every
//   PERIOD = CLOCK_SPEED_HZ / UPDATE_FREQ_HZ cycles. Each accepted tick starts a
//   round that visits the enabled sensors in ascending index order. For each
//   sensor the block selects its chip select, hands a request to the SPI
//   master, waits for the returned frame (bounded by TIMEOUT_CYCLES) and
//   checks it. Good frames update that sensor's angle and fire a one-cycle
//   update strobe that paces the downstream PD controller / PWM latch.
//
// Ports:
//   clock        system clock
//   reset        asynchronous, active-high reset
//   enable       1 = new rounds may start (a running round always completes)
//   sensor_mask  per-sensor poll enable, sampled when each index is scanned
//   spi_req      transfer request to the SPI master, held until spi_ack
//   spi_ack      master accepted the request (1-cycle pulse)
//   spi_done     transfer complete, spi_rdata valid (1-cycle pulse)
//   spi_rdata    received 16-bit frame
//   ss_n_o       active-low chip selects, at most one low at a time
//   angle_o      last good 12-bit angle per sensor, sensor i at [12i+11:12i]
//   cycle_o      1-cycle strobe when angle i was updated
//   round_done   1-cycle strobe at the end of a round
//   busy         a round is in progress
//   error_count  saturating count of bad frames and timeouts
//   overrun      sticky: a tick arrived while a round was still running
//
// Build option:
//   ANGLE_POLL_RETRY_EN - when defined, a bad frame or a timeout triggers
//   exactly one re-request of the same sensor (after a 1-cycle deselect);
//   error_count only increments if that retry also fails. When undefined,
//   every failure counts and the scheduler advances immediately.
// -----------------------------------------------------------------------------
module msj_angle_poll_scheduler #(
  parameter int NUMBER_OF_SENSORS = 6,
  parameter int CLOCK_SPEED_HZ    = 50_000_000,
  parameter int UPDATE_FREQ_HZ    = 1000,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [NUMBER_OF_SENSORS-1:0]    sensor_mask,
  output logic                            spi_req,
  input  logic                            spi_ack,
  input  logic                            spi_done,
  input  logic [15:0]                     spi_rdata,
  output logic [NUMBER_OF_SENSORS-1:0]    ss_n_o,
  output logic [NUMBER_OF_SENSORS*12-1:0] angle_o,
  output logic [NUMBER_OF_SENSORS-1:0]    cycle_o,
  output logic                            round_done,
  output logic                            busy,
  output logic [15:0]                     error_count,
  output logic                            overrun
);

  localparam int PERIOD = CLOCK_SPEED_HZ / UPDATE_FREQ_HZ;
  localparam int TICK_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int IDX_W  = (NUMBER_OF_SENSORS > 1) ? $clog2(NUMBER_OF_SENSORS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PERIOD - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUMBER_OF_SENSORS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_CHECK = 3'd4,
    S_END   = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [TICK_W-1:0]  r_tick_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [TO_W-1:0]    r_to_cnt;
  logic [15:0]        r_rdata;
  logic [15:0]        r_error_count;
  logic               r_busy;
  logic               r_overrun;

  logic               w_tick;
  logic               w_start;
  logic               w_last;
  logic               w_mask_bit;
  logic               w_to_hit;
  logic               w_frame_good;
  logic               w_store;
  logic               w_err_inc;
  logic               w_select;
  logic               w_retry_avail;
  logic               w_forced_bad;

  // ---------------------------------------------------------------------------
  // Rate timer: free-running regardless of enable so the poll rate stays
  // locked to the clock even while polling is paused.
  // ---------------------------------------------------------------------------
  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared decode
  // ---------------------------------------------------------------------------
  assign w_start    = w_tick & enable & (|sensor_mask);
  assign w_last     = (r_idx == IDX_LAST);
  assign w_mask_bit = sensor_mask[r_idx];
  assign w_to_hit   = (r_to_cnt == TO_LAST);

  // A1339 frames carry odd parity over all 16 bits; bit 13 is the sensor's
  // own error flag. A timeout (retry build) is treated as a bad frame so the
  // retry decision lives in a single place (CHECK).
  assign w_frame_good = (^r_rdata) & ~r_rdata[13] & ~w_forced_bad;
  assign w_store      = (r_state == S_CHECK) & w_frame_good;

`ifdef ANGLE_POLL_RETRY_EN
  logic r_retry_used;
  logic r_timed_out;

  assign w_retry_avail = ~r_retry_used;
  assign w_forced_bad  = r_timed_out;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_retry_used <= 1'b0;
      r_timed_out  <= 1'b0;
    end else begin
      // Fresh retry budget for every sensor visited.
      if (r_state == S_SCAN) begin
        r_retry_used <= 1'b0;
      end else if ((r_state == S_CHECK) && (w_state_next == S_REQ)) begin
        r_retry_used <= 1'b1;
      end

      if (r_state == S_REQ) begin
        r_timed_out <= 1'b0;
      end else if ((r_state == S_WAIT) && !spi_done && w_to_hit) begin
        r_timed_out <= 1'b1;
      end
    end
  end
`else
  assign w_retry_avail = 1'b0;
  assign w_forced_bad  = 1'b0;
`endif

  // A failure is only counted once no retry remains for this sensor.
  assign w_err_inc = ((r_state == S_WAIT) & ~spi_done & w_to_hit & ~w_retry_avail) |
                     ((r_state == S_CHECK) & ~w_frame_good & ~w_retry_avail);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_next = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_mask_bit) begin
          w_state_next = S_REQ;
        end else if (w_last) begin
          w_state_next = S_END;
        end else begin
          w_state_next = S_SCAN;
        end
      end
      S_REQ: begin
        if (spi_ack) begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (spi_done) begin
          w_state_next = S_CHECK;
        end else if (w_to_hit) begin
          // With a retry pending, CHECK provides the 1-cycle deselect and
          // sends us back to REQ; otherwise advance straight away (the
          // following SCAN/END cycle is the deselect gap).
          if (w_retry_avail) begin
            w_state_next = S_CHECK;
          end else if (w_last) begin
            w_state_next = S_END;
          end else begin
            w_state_next = S_SCAN;
          end
        end
      end
      S_CHECK: begin
        if (!w_frame_good && w_retry_avail) begin
          w_state_next = S_REQ;
        end else if (w_last) begin
          w_state_next = S_END;
        end else begin
          w_state_next = S_SCAN;
        end
      end
      S_END: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Decoded straight from the state so an asynchronous reset
  // releases the bus (spi_req low, all selects high) in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    spi_req    = 1'b0;
    round_done = 1'b0;
    w_select   = 1'b0;
    unique case (r_state)
      S_REQ: begin
        spi_req  = 1'b1;
        w_select = 1'b1;
      end
      S_WAIT: begin
        w_select = 1'b1;
      end
      S_END: begin
        round_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Round datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx         <= '0;
      r_to_cnt      <= '0;
      r_rdata       <= '0;
      r_error_count <= '0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      // Every path back into SCAN from a non-IDLE state moves to the next
      // index, so the increment keys off the next state alone.
      if (r_state == S_IDLE) begin
        r_idx <= '0;
      end else if (w_state_next == S_SCAN) begin
        r_idx <= r_idx + 1'b1;
      end

      if (r_state == S_REQ) begin
        r_to_cnt <= '0;
      end else if ((r_state == S_WAIT) && !w_to_hit) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      if ((r_state == S_WAIT) && spi_done) begin
        r_rdata <= spi_rdata;
      end

      if (w_err_inc && (r_error_count != 16'hFFFF)) begin
        r_error_count <= r_error_count + 16'd1;
      end

      if ((r_state == S_IDLE) && w_start) begin
        r_busy <= 1'b1;
      end else if (r_state == S_END) begin
        r_busy <= 1'b0;
      end

      // Ticks never queue: one arriving mid-round is dropped and flagged.
      if (w_tick && r_busy) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign busy        = r_busy;
  assign overrun     = r_overrun;
  assign error_count = r_error_count;

  // ---------------------------------------------------------------------------
  // Per-sensor chip select, angle register and update strobe
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUMBER_OF_SENSORS; gi++) begin : g_sensor
      logic        w_hit;
      logic [11:0] r_angle;
      logic        r_cycle;

      assign w_hit = (r_idx == IDX_W'(gi));

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_angle <= '0;
          r_cycle <= 1'b0;
        end else begin
          r_cycle <= w_store & w_hit;
          if (w_store && w_hit) begin
            r_angle <= r_rdata[11:0];
          end
        end
      end

      assign ss_n_o[gi]           = ~(w_select & w_hit);
      assign angle_o[12*gi +: 12] = r_angle;
      assign cycle_o[gi]          = r_cycle;
    end
  endgenerate

endmodule

// File: tb/tb_msj_angle_poll_scheduler.sv
module tb_msj_angle_poll_scheduler;

  localparam int N      = 6;
  localparam int CLK_HZ = 400_000;
  localparam int UPD_HZ = 1000;
  localparam int PERIOD = CLK_HZ / UPD_HZ;   // 400 cycles
  localparam int TO     = 1024;
  localparam int BUDGET = 2 * PERIOD + N * (TO + 80);

  logic            clock;
  logic            reset;
  logic            enable;
  logic [N-1:0]    sensor_mask;
  logic            spi_req;
  logic            spi_ack;
  logic            spi_done;
  logic [15:0]     spi_rdata;
  logic [N-1:0]    ss_n_o;
  logic [N*12-1:0] angle_o;
  logic [N-1:0]    cycle_o;
  logic            round_done;
  logic            busy;
  logic [15:0]     error_count;
  logic            overrun;

  msj_angle_poll_scheduler #(
    .NUMBER_OF_SENSORS(N),
    .CLOCK_SPEED_HZ   (CLK_HZ),
    .UPDATE_FREQ_HZ   (UPD_HZ),
    .TIMEOUT_CYCLES   (TO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .sensor_mask(sensor_mask),
    .spi_req    (spi_req),
    .spi_ack    (spi_ack),
    .spi_done   (spi_done),
    .spi_rdata  (spi_rdata),
    .ss_n_o     (ss_n_o),
    .angle_o    (angle_o),
    .cycle_o    (cycle_o),
    .round_done (round_done),
    .busy       (busy),
    .error_count(error_count),
    .overrun    (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- SPI master / sensor model ----------------
  logic [15:0] cfg_frame [N];
  int          cfg_lat;
  logic [N-1:0] cfg_nodone;

  initial begin
    int sel;
    bit aborted;
    spi_ack   = 1'b0;
    spi_done  = 1'b0;
    spi_rdata = 16'h0;
    forever begin
      @(negedge clock);
      if (spi_req && !reset) begin
        sel = 0;
        for (int i = N - 1; i >= 0; i--) if (!ss_n_o[i]) sel = i;
        spi_ack = 1'b1;
        @(negedge clock);
        spi_ack = 1'b0;
        aborted = 1'b0;
        for (int k = 1; k < cfg_lat && !aborted; k++) begin
          @(negedge clock);
          if (reset) aborted = 1'b1;
        end
        if (!aborted && !cfg_nodone[sel]) begin
          spi_rdata = cfg_frame[sel];
          spi_done  = 1'b1;
          @(negedge clock);
          spi_done  = 1'b0;
        end
      end
    end
  end

  // ---------------- Bus monitor ----------------
  logic         mon_clr;
  logic [N-1:0] mon_polled, mon_cycle;
  int mon_cycle_cnt, mon_rd_cnt, mon_order_err, mon_inv_err;
  int mon_last_idx, mon_first_idx, mon_busy_cnt, mon_wait_run, mon_wait_max;
  logic prev_req;

  always @(negedge clock) begin
    int zeros;
    int low;
    if (mon_clr) begin
      mon_polled = '0; mon_cycle = '0; mon_cycle_cnt = 0; mon_rd_cnt = 0;
      mon_order_err = 0; mon_inv_err = 0; mon_last_idx = -1; mon_first_idx = -1;
      mon_busy_cnt = 0; mon_wait_run = 0; mon_wait_max = 0; prev_req = 1'b0;
    end else begin
      zeros = 0;
      low   = -1;
      for (int i = N - 1; i >= 0; i--) if (!ss_n_o[i]) begin zeros++; low = i; end
      if (zeros > 1) mon_inv_err++;
      if (spi_req && zeros != 1) mon_inv_err++;
      if (spi_req && !prev_req && low >= 0) begin
        mon_polled[low] = 1'b1;
        if (mon_first_idx < 0) mon_first_idx = low;
        if (low <= mon_last_idx) mon_order_err++;
        mon_last_idx = low;
      end
      prev_req = spi_req;
      mon_cycle |= cycle_o;
      mon_cycle_cnt += $countones(cycle_o);
      if (round_done) mon_rd_cnt++;
      if (busy) mon_busy_cnt++;
      if (zeros == 1 && !spi_req) mon_wait_run++; else mon_wait_run = 0;
      if (mon_wait_run > mon_wait_max) mon_wait_max = mon_wait_run;
    end
  end

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clock);
    #1 mon_clr = 1'b0;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    reset  = 1'b1;
    repeat (2) @(negedge clock);
    reset  = 1'b0;
    @(negedge clock);
  endtask

  // Start one round and wait (bounded) for its round_done.
  task automatic run_round(input string name);
    bit ok;
    ok = 1'b0;
    enable = 1'b1;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clock);
      if (round_done) begin ok = 1'b1; break; end
    end
    enable = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s round_done: not seen within %0d cycles", name, BUDGET);
    end
  endtask

  // ---------------- Directed vector table ----------------
  typedef struct {
    logic [5:0]  mask;
    logic [95:0] frames;      // sensor i at [16i+15:16i]
    int          lat;
    logic [5:0]  nodone;
    logic [5:0]  exp_polled;
    logic [5:0]  exp_cycle;
    int          exp_err;
    logic [71:0] exp_angle;
    logic        exp_ovr;
  } vec_t;

  vec_t vecs [8];

  // Behavioural reference state for the random phase
  logic [11:0] m_angle [N];
  int          m_err;

  initial begin
    string nm;
    logic [71:0] exp_a;
    logic [5:0]  exp_c, r_mask, r_nodone;
    logic [15:0] f;

    vecs[0] = '{6'h3F, {6{16'h0ABC}}, 40, 6'h00, 6'h3F, 6'h3F, 0, {6{12'hABC}}, 1'b0};
    vecs[1] = '{6'h25, {6{16'h0ABC}}, 40, 6'h00, 6'h25, 6'h25, 0, 72'hABC_000_000_ABC_000_ABC, 1'b0};
    vecs[2] = '{6'h3F, 96'h0ABC_0ABC_0ABD_0ABC_0ABC_0ABC, 40, 6'h00, 6'h3F, 6'h37, 1,
                72'hABC_ABC_000_ABC_ABC_ABC, 1'b0};
    vecs[3] = '{6'h3F, 96'h0ABC_0ABC_0ABC_0ABC_0ABC_2ABD, 40, 6'h00, 6'h3F, 6'h3E, 1,
                72'hABC_ABC_ABC_ABC_ABC_000, 1'b0};
    vecs[4] = '{6'h12, 96'h0ABC_0001_0ABC_0ABC_D123_0ABC, 10, 6'h00, 6'h12, 6'h12, 0,
                72'h000_001_000_000_123_000, 1'b0};
    vecs[5] = '{6'h07, {6{16'h0ABC}}, 40, 6'h02, 6'h07, 6'h05, 1,
                72'h000_000_000_ABC_000_ABC, 1'b1};
    vecs[6] = '{6'h3F, {6{16'h1555}}, 70, 6'h00, 6'h3F, 6'h3F, 0, {6{12'h555}}, 1'b1};
    vecs[7] = '{6'h3F, 96'h2000_0ABC_8FFF_7FFF_FFFF_0000, 20, 6'h00, 6'h3F, 6'h18, 4,
                72'h000_ABC_FFF_000_000_000, 1'b0};

    mon_clr = 1'b1;
    reset = 1'b0; enable = 1'b0; sensor_mask = '0;
    cfg_lat = 40; cfg_nodone = '0;
    for (int i = 0; i < N; i++) cfg_frame[i] = 16'h0ABC;

    // Reset state
    do_reset();
    check("reset spi_req",     72'(spi_req),     72'(0));
    check("reset ss_n_o",      72'(ss_n_o),      72'(6'h3F));
    check("reset angle_o",     72'(angle_o),     72'(0));
    check("reset cycle_o",     72'(cycle_o),     72'(0));
    check("reset round_done",  72'(round_done),  72'(0));
    check("reset busy",        72'(busy),        72'(0));
    check("reset error_count", 72'(error_count), 72'(0));
    check("reset overrun",     72'(overrun),     72'(0));

    // Table-driven rounds, each from a fresh reset
    for (int v = 0; v < 8; v++) begin
      do_reset();
      for (int i = 0; i < N; i++) cfg_frame[i] = vecs[v].frames[16*i +: 16];
      cfg_lat     = vecs[v].lat;
      cfg_nodone  = vecs[v].nodone;
      sensor_mask = vecs[v].mask;
      clear_mon();
      nm = $sformatf("vec%0d", v);
      run_round(nm);
      $display("vec%0d mask=%h polled=%h cycle=%h err=%0d angle=%h ovr=%0b",
               v, vecs[v].mask, mon_polled, mon_cycle, error_count, angle_o, overrun);
      check({nm, " polled"},    72'(mon_polled),    72'(vecs[v].exp_polled));
      check({nm, " cycle_o"},   72'(mon_cycle),     72'(vecs[v].exp_cycle));
      check({nm, " cycle_cnt"}, 72'(mon_cycle_cnt), 72'($countones(vecs[v].exp_cycle)));
      check({nm, " err"},       72'(error_count),   72'(vecs[v].exp_err));
      check({nm, " angle"},     angle_o,            vecs[v].exp_angle);
      check({nm, " overrun"},   72'(overrun),       72'(vecs[v].exp_ovr));
      check({nm, " rounds"},    72'(mon_rd_cnt),    72'(1));
      check({nm, " order"},     72'(mon_order_err), 72'(0));
      check({nm, " onehot_ss"}, 72'(mon_inv_err),   72'(0));
      check({nm, " busy_end"},  72'(busy),          72'(0));
      if (vecs[v].nodone != 0) check({nm, " timeout_len"}, 72'(mon_wait_max), 72'(TO));
    end

    // Hand sequence: asynchronous reset while waiting on sensor 2
    do_reset();
    for (int i = 0; i < N; i++) cfg_frame[i] = 16'h0ABC;
    cfg_lat = 40; cfg_nodone = '0; sensor_mask = 6'h3F;
    enable = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < BUDGET; c++) begin
        @(negedge clock);
        if (!ss_n_o[2] && !spi_req) begin seen = 1'b1; break; end
      end
      check("rst_wait reached", 72'(seen), 72'(1));
    end
    check("rst_wait pre angle0", 72'(angle_o[11:0]), 72'(12'hABC));
    reset = 1'b1;
    #1;
    check("rst_wait spi_req", 72'(spi_req),     72'(0));
    check("rst_wait ss_n_o",  72'(ss_n_o),      72'(6'h3F));
    check("rst_wait busy",    72'(busy),        72'(0));
    check("rst_wait angle",   72'(angle_o),     72'(0));
    check("rst_wait err",     72'(error_count), 72'(0));
    enable = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    clear_mon();
    run_round("rst_restart");
    $display("rst_restart first=%0d polled=%h angle=%h", mon_first_idx, mon_polled, angle_o);
    check("rst_restart first_idx", 72'(mon_first_idx), 72'(0));
    check("rst_restart polled",    72'(mon_polled),    72'(6'h3F));
    check("rst_restart angle",     angle_o,            {6{12'hABC}});

    // Hand sequence: enable dropped mid-round, then idle behaviour
    do_reset();
    sensor_mask = 6'h3F;
    clear_mon();
    enable = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < BUDGET; c++) begin
        @(negedge clock);
        if (spi_req) begin seen = 1'b1; break; end
      end
      enable = 1'b0;
      for (int c = 0; c < BUDGET && seen; c++) begin
        @(negedge clock);
        if (round_done) break;
      end
    end
    repeat (3) @(negedge clock);
    $display("en_drop polled=%h rounds=%0d", mon_polled, mon_rd_cnt);
    check("en_drop polled", 72'(mon_polled), 72'(6'h3F));
    check("en_drop rounds", 72'(mon_rd_cnt), 72'(1));
    clear_mon();
    repeat (2 * PERIOD + 10) @(negedge clock);
    check("en_off no_round", 72'(mon_busy_cnt), 72'(0));
    sensor_mask = '0;
    enable = 1'b1;
    clear_mon();
    repeat (2 * PERIOD + 10) @(negedge clock);
    enable = 1'b0;
    check("mask0 no_round", 72'(mon_busy_cnt), 72'(0));

    // Randomised rounds against the behavioural model (no reset between rounds)
    do_reset();
    for (int i = 0; i < N; i++) m_angle[i] = 12'h0;
    m_err = 0;
    for (int r = 0; r < 12; r++) begin
      r_mask   = 6'($urandom_range(1, 63));
      r_nodone = '0;
      if (r % 4 == 3) r_nodone[$urandom_range(0, N - 1)] = 1'b1;
      cfg_lat = $urandom_range(2, 30);
      for (int i = 0; i < N; i++) begin
        f = 16'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          f[13] = 1'b0;
          if (^f == 1'b0) f[14] = ~f[14];
        end
        cfg_frame[i] = f;
      end
      cfg_nodone  = r_nodone;
      sensor_mask = r_mask;
      exp_c = '0;
      for (int i = 0; i < N; i++) begin
        if (r_mask[i]) begin
          if (r_nodone[i]) m_err++;
          else if ((^cfg_frame[i]) && !cfg_frame[i][13]) begin
            m_angle[i] = cfg_frame[i][11:0];
            exp_c[i]   = 1'b1;
          end else m_err++;
        end
      end
      exp_a = '0;
      for (int i = 0; i < N; i++) exp_a[12*i +: 12] = m_angle[i];
      clear_mon();
      nm = $sformatf("rnd%0d", r);
      run_round(nm);
      $display("rnd%0d mask=%h lat=%0d nodone=%h cycle=%h err=%0d angle=%h",
               r, r_mask, cfg_lat, r_nodone, mon_cycle, error_count, angle_o);
      check({nm, " angle"},  angle_o,          exp_a);
      check({nm, " err"},    72'(error_count), 72'(m_err));
      check({nm, " cycle"},  72'(mon_cycle),   72'(exp_c));
      check({nm, " polled"}, 72'(mon_polled),  72'(r_mask));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
